// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader_pkg
//  Purpose  : Shared state encoding for the ram_loader FSM.
//  Contents : c_st_* state constants and the state_t enum that uses them.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_dump = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_st_idle,
        LOAD = c_st_load,
        DUMP = c_st_dump
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_addr_counter
//  Purpose  : A-bit address counter with synchronous clear, count enable
//             and a terminal-count flag (count == 2^A-1).
//  Ports    : clk, rst (async, active-high)
//             i_clear - zero the counter (wins over i_en)
//             i_en    - advance the counter by one, wrapping at 2^A
//             o_count - current count
//             o_tc    - high while the count is at its maximum
//  Revision : 1.0 - initial release
// ============================================================================
module ram_addr_counter #(
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [A-1:0] o_count,
    output logic         o_tc
);

    logic [A-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = &r_count;

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader
//  Purpose  : Fills an external RAM from a valid/ready word stream (LOAD)
//             or streams its contents out through a valid/ready port (DUMP).
//  Ports    : clk, reset (async, active-high)
//             load_start / dump_start / abort  - command inputs (IDLE only
//                                                for the two starts)
//             in_valid / in_data / in_ready    - load-side stream
//             out_valid / out_data / out_ready - dump-side stream
//             ram_addr / ram_din / ram_we / ram_dout - external RAM port
//             busy  - FSM not in IDLE
//             done  - one-cycle pulse after the last word of an operation
//             checksum - XOR of loaded words (RAM_LOADER_CHECKSUM_EN only)
//  Config   : RAM_LOADER_CHECKSUM_EN adds the checksum port and register.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int A = 4,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic         dump_start,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [D-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [D-1:0] out_data,
    input  logic         out_ready,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout,
    output logic         busy,
    output logic         done
`ifdef RAM_LOADER_CHECKSUM_EN
    ,
    output logic [D-1:0] checksum
`endif
);

    state_t       r_state;
    state_t       w_next;
    logic         r_done;
    logic         w_done_next;
    logic         w_clear;
    logic         w_en;
    logic         w_tc;
    logic         w_load_go;
    logic         w_accept;
    logic [A-1:0] w_count;

    ram_addr_counter #(
        .A(A)
    ) u_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_clear),
        .i_en    (w_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        w_clear     = 1'b0;
        w_en        = 1'b0;
        w_load_go   = 1'b0;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        ram_din     = '0;
        ram_we      = 1'b0;

        case (r_state)
            IDLE: begin
                // load_start has priority; a simultaneous dump_start is dropped.
                if (load_start) begin
                    w_next    = LOAD;
                    w_clear   = 1'b1;
                    w_load_go = 1'b1;
                end else if (dump_start) begin
                    w_next  = DUMP;
                    w_clear = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                ram_din  = in_data;
                ram_we   = in_valid;
                w_accept = in_valid;
                // On abort the word in flight is still written, but the
                // counter stays put and no done pulse is raised.
                if (abort) begin
                    w_next = IDLE;
                end else if (in_valid) begin
                    w_en = 1'b1;
                    if (w_tc) begin
                        w_next      = IDLE;
                        w_done_next = 1'b1;
                    end
                end
            end
            DUMP: begin
                out_valid = 1'b1;
                out_data  = ram_dout;
                if (abort) begin
                    w_next = IDLE;
                end else if (out_ready) begin
                    w_en = 1'b1;
                    if (w_tc) begin
                        w_next      = IDLE;
                        w_done_next = 1'b1;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign ram_addr = w_count;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [D-1:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_load_go) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum ^ in_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire
